ghost_chase: RTL and testbench

GHOST_CHASE -- requirements
Module: ghost_chase

---
 rtl/ghost_chase.sv | 210 +++++++++++++++++++++
 tb/tb_ghost_chase.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_chase.sv
// ghost_chase: per-frame ghost movement controller for a maze game.
//   frame_clk            : one rising edge per video frame
//   Reset                : asynchronous, active-high; returns the ghost to its start
//   PacX/PacY/PacDir     : player top-left position and heading (0 up,1 left,2 down,3 right,4 idle)
//   WallUp/Down/Left/Right : wall present one pixel beyond the ghost's current edge
//   GhostX/GhostY        : ghost top-left position
//   GhostDir             : ghost heading, same encoding as PacDir
//   Mode                 : 0 SCATTER, 1 CHASE, 2 CAUGHT
//   Caught               : high while Mode is CAUGHT
module ghost_chase #(
  parameter int GHOST_X_START  = 480,
  parameter int GHOST_Y_START  = 230,
  parameter int STEP           = 2,
  parameter int SIZE           = 16,
  parameter int SCATTER_FRAMES = 140,
  parameter int CHASE_FRAMES   = 420
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] PacX,
  input  logic [9:0] PacY,
  input  logic [2:0] PacDir,
  input  logic       WallUp,
  input  logic       WallDown,
  input  logic       WallLeft,
  input  logic       WallRight,
  output logic [9:0] GhostX,
  output logic [9:0] GhostY,
  output logic [2:0] GhostDir,
  output logic [1:0] Mode,
  output logic       Caught
);

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_IDLE  = 3'd4;

  localparam logic signed [11:0] X_MAX   = 12'(640 - SIZE);
  localparam logic signed [11:0] Y_MAX   = 12'(480 - SIZE);
  localparam logic signed [11:0] TGT_MAX = 12'sd624;
  localparam logic signed [11:0] TGT_OFS = 12'sd32;
  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] SIZE_S  = 12'(SIZE);
  localparam logic [9:0]         SCATTER_TGT = 10'd16;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    CAUGHT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [2:0]  r_dir;

  // Opposite heading; idle has no opposite.
  function automatic logic [2:0] f_rev(input logic [2:0] d);
    if (d[2]) return DIR_IDLE;
    return {1'b0, d[1:0] + 2'd2};
  endfunction

  // walls is indexed by heading: bit0 up, bit1 left, bit2 down, bit3 right.
  function automatic logic f_blocked(input logic [2:0] d, input logic [3:0] walls);
    if (d[2]) return 1'b1;
    return walls[d[1:0]];
  endfunction

  function automatic logic signed [11:0] f_abs(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

  function automatic logic [9:0] f_sat(input logic signed [11:0] v,
                                       input logic signed [11:0] hi);
    if (v < 12'sd0) return 10'd0;
    if (v > hi)     return hi[9:0];
    return v[9:0];
  endfunction

  logic [3:0]         w_walls;
  logic signed [10:0] w_ovx, w_ovy;
  logic               w_overlap;
  logic               w_timeout;
  logic signed [11:0] w_tx_raw, w_ty_raw;
  logic [9:0]         w_tx, w_ty;
  logic signed [10:0] w_dx, w_dy;
  logic               w_x_primary;
  logic [2:0]         w_x_tow, w_y_tow, w_pri, w_sec;
  logic [2:0]         w_cand [4];
  logic [2:0]         w_rev;
  logic               w_rev_ok;
  logic [2:0]         w_choice;
  logic               w_found;
  logic signed [11:0] w_nx_raw, w_ny_raw;
  logic [9:0]         w_nx, w_ny;

  assign w_walls = {WallRight, WallDown, WallLeft, WallUp};

  // Catch test on the raw positions, before any move this frame.
  assign w_ovx     = $signed({1'b0, r_x}) - $signed({1'b0, PacX});
  assign w_ovy     = $signed({1'b0, r_y}) - $signed({1'b0, PacY});
  assign w_overlap = (f_abs({w_ovx[10], w_ovx}) < SIZE_S) &&
                     (f_abs({w_ovy[10], w_ovy}) < SIZE_S);

  assign w_timeout = ((r_state == SCATTER) && (r_cnt == 16'(SCATTER_FRAMES - 1))) ||
                     ((r_state == CHASE)   && (r_cnt == 16'(CHASE_FRAMES - 1)));

  // Chase target: player position pushed 32 px ahead of its heading.
  always_comb begin
    w_tx_raw = $signed({2'b00, PacX});
    w_ty_raw = $signed({2'b00, PacY});
    case (PacDir)
      DIR_UP:    w_ty_raw = w_ty_raw - TGT_OFS;
      DIR_LEFT:  w_tx_raw = w_tx_raw - TGT_OFS;
      DIR_DOWN:  w_ty_raw = w_ty_raw + TGT_OFS;
      DIR_RIGHT: w_tx_raw = w_tx_raw + TGT_OFS;
      default:   ;
    endcase
  end

  assign w_tx = (r_state == CHASE) ? f_sat(w_tx_raw, TGT_MAX) : SCATTER_TGT;
  assign w_ty = (r_state == CHASE) ? f_sat(w_ty_raw, TGT_MAX) : SCATTER_TGT;

  assign w_dx        = $signed({1'b0, w_tx}) - $signed({1'b0, r_x});
  assign w_dy        = $signed({1'b0, w_ty}) - $signed({1'b0, r_y});
  assign w_x_primary = f_abs({w_dx[10], w_dx}) >= f_abs({w_dy[10], w_dy});
  // A zero delta counts as "toward" in the positive direction.
  assign w_x_tow     = w_dx[10] ? DIR_LEFT : DIR_RIGHT;
  assign w_y_tow     = w_dy[10] ? DIR_UP   : DIR_DOWN;
  assign w_pri       = w_x_primary ? w_x_tow : w_y_tow;
  assign w_sec       = w_x_primary ? w_y_tow : w_x_tow;

  assign w_rev    = f_rev(r_dir);
  assign w_rev_ok = (r_dir != DIR_IDLE) && !f_blocked(w_rev, w_walls);

  // First open non-reversing candidate wins; reversing only as a last resort.
  always_comb begin
    w_cand[0] = w_pri;
    w_cand[1] = w_sec;
    w_cand[2] = f_rev(w_sec);
    w_cand[3] = f_rev(w_pri);
    w_choice  = DIR_IDLE;
    w_found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && !f_blocked(w_cand[i], w_walls) && (w_cand[i] != w_rev)) begin
        w_choice = w_cand[i];
        w_found  = 1'b1;
      end
    end
    if (!w_found && w_rev_ok) w_choice = w_rev;
  end

  // Move along the chosen heading this same frame, clamped to the screen.
  always_comb begin
    w_nx_raw = $signed({2'b00, r_x});
    w_ny_raw = $signed({2'b00, r_y});
    case (w_choice)
      DIR_UP:    w_ny_raw = w_ny_raw - STEP_S;
      DIR_LEFT:  w_nx_raw = w_nx_raw - STEP_S;
      DIR_DOWN:  w_ny_raw = w_ny_raw + STEP_S;
      DIR_RIGHT: w_nx_raw = w_nx_raw + STEP_S;
      default:   ;
    endcase
  end

  assign w_nx = f_sat(w_nx_raw, X_MAX);
  assign w_ny = f_sat(w_ny_raw, Y_MAX);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= SCATTER;
      r_cnt   <= 16'd0;
      r_x     <= 10'(GHOST_X_START);
      r_y     <= 10'(GHOST_Y_START);
      r_dir   <= DIR_IDLE;
    end else begin
      case (r_state)
        CAUGHT: r_dir <= DIR_IDLE;
        default: begin
          if (w_overlap) begin
            // Catch wins over the mode timer; the ghost stops where it is.
            r_state <= CAUGHT;
            r_cnt   <= 16'd0;
            r_dir   <= DIR_IDLE;
          end else if (w_timeout) begin
            // Mode flip: turn around if possible, no movement this frame.
            r_state <= (r_state == SCATTER) ? CHASE : SCATTER;
            r_cnt   <= 16'd0;
            if (w_rev_ok) r_dir <= w_rev;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            r_dir <= w_choice;
            r_x   <= w_nx;
            r_y   <= w_ny;
          end
        end
      endcase
    end
  end

  assign GhostX   = r_x;
  assign GhostY   = r_y;
  assign GhostDir = r_dir;
  assign Mode     = r_state;
  assign Caught   = (r_state == CAUGHT);

endmodule

// File: tb/tb_ghost_chase.sv
// tb_ghost_chase: directed scenarios followed by randomized frames for ghost_chase,
// with every output compared against a frame-level behavioural model of the ghost.
module tb_ghost_chase;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b0;
  logic [9:0] PacX      = 10'd0;
  logic [9:0] PacY      = 10'd0;
  logic [2:0] PacDir    = 3'd4;
  logic       WallUp    = 1'b0;
  logic       WallDown  = 1'b0;
  logic       WallLeft  = 1'b0;
  logic       WallRight = 1'b0;
  logic [9:0] GhostX;
  logic [9:0] GhostY;
  logic [2:0] GhostDir;
  logic [1:0] Mode;
  logic       Caught;

  ghost_chase dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .PacX(PacX), .PacY(PacY), .PacDir(PacDir),
    .WallUp(WallUp), .WallDown(WallDown), .WallLeft(WallLeft), .WallRight(WallRight),
    .GhostX(GhostX), .GhostY(GhostY), .GhostDir(GhostDir), .Mode(Mode), .Caught(Caught)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  // Model state: position, heading (4 = idle), mode (0/1/2) and frames in mode.
  int m_x, m_y, m_dir, m_mode, m_cnt;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int opp(input int d);
    return (d + 2) % 4;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_x = 480; m_y = 230; m_dir = 4; m_mode = 0; m_cnt = 0;
  endtask

  // One frame of the game rules, using the inputs present at the clock edge.
  task automatic model_step();
    int wl[4];
    int tx, ty, dx, dy, pt, st, rev, choice;
    int order[4];
    int mvx[4];
    int mvy[4];
    wl  = '{int'(WallUp), int'(WallLeft), int'(WallDown), int'(WallRight)};
    mvx = '{0, -2, 0, 2};
    mvy = '{-2, 0, 2, 0};
    if (m_mode == 2) return;
    if (iabs(m_x - int'(PacX)) < 16 && iabs(m_y - int'(PacY)) < 16) begin
      m_mode = 2; m_dir = 4; m_cnt = 0;
      return;
    end
    if ((m_mode == 0 && m_cnt == 139) || (m_mode == 1 && m_cnt == 419)) begin
      m_mode = 1 - m_mode;
      m_cnt  = 0;
      if (m_dir != 4 && wl[opp(m_dir)] == 0) m_dir = opp(m_dir);
      return;
    end
    m_cnt++;
    if (m_mode == 0) begin
      tx = 16; ty = 16;
    end else begin
      tx = int'(PacX); ty = int'(PacY);
      if (PacDir == 0) ty -= 32;
      if (PacDir == 1) tx -= 32;
      if (PacDir == 2) ty += 32;
      if (PacDir == 3) tx += 32;
      tx = clampi(tx, 0, 624);
      ty = clampi(ty, 0, 624);
    end
    dx = tx - m_x;
    dy = ty - m_y;
    pt = (dx >= 0) ? 3 : 1;
    st = (dy >= 0) ? 2 : 0;
    if (iabs(dx) >= iabs(dy)) order = '{pt, st, opp(st), opp(pt)};
    else                      order = '{st, pt, opp(pt), opp(st)};
    rev    = (m_dir == 4) ? -1 : opp(m_dir);
    choice = 4;
    for (int i = 0; i < 4; i++)
      if (choice == 4 && wl[order[i]] == 0 && order[i] != rev) choice = order[i];
    if (choice == 4 && rev >= 0 && wl[rev] == 0) choice = rev;
    m_dir = choice;
    if (choice < 4) begin
      m_x = clampi(m_x + mvx[choice], 0, 624);
      m_y = clampi(m_y + mvy[choice], 0, 464);
    end
  endtask

  task automatic check_all();
    chk("GhostX",   32'(GhostX),   m_x);
    chk("GhostY",   32'(GhostY),   m_y);
    chk("GhostDir", 32'(GhostDir), m_dir);
    chk("Mode",     32'(Mode),     m_mode);
    chk("Caught",   32'(Caught),   (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge frame_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic set_walls(input logic u, input logic l, input logic d, input logic r);
    WallUp = u; WallLeft = l; WallDown = d; WallRight = r;
  endtask

  initial begin
    int pd, px, py;

    // Reset state, then scatter toward (16,16) and the mode flip at frame 140.
    do_reset();
    PacX = 10'd160; PacY = 10'd230; PacDir = 3'd4;
    set_walls(0, 0, 0, 0);
    step();
    chk("first_move_dir", 32'(GhostDir), 1);
    chk("first_move_x",   32'(GhostX),   478);
    for (int f = 1; f < 139; f++) step();
    pd = m_dir; px = m_x; py = m_y;
    chk("pre_flip_mode", 32'(Mode), 0);
    step();
    chk("flip_mode",   32'(Mode),     1);
    chk("flip_dir",    32'(GhostDir), opp(pd));
    chk("flip_hold_x", 32'(GhostX),   px);
    chk("flip_hold_y", 32'(GhostY),   py);

    // All walls: ghost stalls idle while the chase timer keeps running.
    set_walls(1, 1, 1, 1);
    step();
    chk("boxed_dir",    32'(GhostDir), 4);
    chk("boxed_hold_x", 32'(GhostX),   px);
    for (int f = 0; f < 418; f++) step();
    chk("chase_end_mode", 32'(Mode), 1);
    step();
    chk("back_to_scatter", 32'(Mode), 0);

    // Heading left, everything but the right wall closed: reversal allowed.
    set_walls(1, 0, 1, 1);
    step();
    chk("head_left", 32'(GhostDir), 1);
    px = m_x;
    set_walls(1, 1, 1, 0);
    step();
    chk("reverse_right",   32'(GhostDir), 3);
    chk("reverse_right_x", 32'(GhostX),   px + 2);

    // Left wall while heading left toward an up-left target: go up.
    do_reset();
    PacX = 10'd160; PacY = 10'd230; PacDir = 3'd4;
    set_walls(0, 0, 0, 0);
    step();
    set_walls(0, 1, 0, 0);
    step();
    chk("sec_toward_dir", 32'(GhostDir), 0);
    chk("sec_toward_y",   32'(GhostY),   228);
    chk("sec_toward_x",   32'(GhostX),   478);

    // Overlap catch, frozen afterwards, then reset out of CAUGHT.
    set_walls(0, 0, 0, 0);
    PacX = 10'd488; PacY = 10'd223;
    step();
    chk("caught_mode", 32'(Mode),   2);
    chk("caught_flag", 32'(Caught), 1);
    for (int f = 0; f < 3; f++) begin
      PacX = 10'($urandom_range(0, 639)); PacY = 10'($urandom_range(0, 479));
      PacDir = 3'($urandom_range(0, 4));
      step();
      chk("caught_frozen_x", 32'(GhostX), 478);
      chk("caught_frozen_y", 32'(GhostY), 228);
    end
    do_reset();
    chk("reset_from_caught_x",    32'(GhostX), 480);
    chk("reset_from_caught_mode", 32'(Mode),   0);

    // Forced right to the screen edge: clamp at 624, then clamped chase target.
    PacX = 10'd0; PacY = 10'd0; PacDir = 3'd4;
    set_walls(1, 1, 1, 0);
    for (int f = 0; f < 139; f++) step();
    chk("edge_clamp_x",   32'(GhostX),   624);
    chk("edge_clamp_dir", 32'(GhostDir), 3);
    step();
    chk("edge_flip_mode", 32'(Mode),     1);
    chk("edge_flip_dir",  32'(GhostDir), 3);
    set_walls(0, 0, 0, 0);
    PacX = 10'd620; PacY = 10'd250; PacDir = 3'd3;
    step();
    chk("clamped_target_dir", 32'(GhostDir), 2);
    chk("clamped_target_x",   32'(GhostX),   624);

    // Randomized frames.
    for (int f = 0; f < 3000; f++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 599) == 0) do_reset();
      WallUp    = ($urandom_range(0, 3) == 0);
      WallLeft  = ($urandom_range(0, 3) == 0);
      WallDown  = ($urandom_range(0, 3) == 0);
      WallRight = ($urandom_range(0, 3) == 0);
      if (f % 16 == 0) begin
        if ($urandom_range(0, 3) == 0) PacX = 10'($urandom_range(600, 639));
        else                           PacX = 10'($urandom_range(0, 639));
        if ($urandom_range(0, 3) == 0) PacY = 10'($urandom_range(0, 20));
        else                           PacY = 10'($urandom_range(0, 479));
      end
      PacDir = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
